smc_stream_topk: RTL and testbench

// - Sequential, parametrised successor of the six-device MOSFET calculator (Kn=1/3, Vth=VTH, no body effect/CLM).
// - Streams N_DEV devices in one per accepted cycle and computes Id or gm for each.
// - Keeps a running sorted list of the results, then emits the weighted sum of the K largest or the K smallest.
// - Sits between the pattern/input interface and the result checker; one batch of N_DEV devices per answer.

---
 rtl/smc_pkg.sv | 20 ++
 rtl/smc_stream_topk_dev_calc.sv | 49 ++++
 rtl/smc_stream_topk.sv | 130 +++++++++++++
 tb/tb_smc_stream_topk.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/smc_pkg.sv
// smc_pkg: shared types and helpers for the streaming MOSFET top-K calculator.
//   state_e  - batch controller states
//   region_e - device operating region
//   MODE_ID / MODE_MAX - bit positions inside the 2-bit mode word
//   weight() - per-slot weight applied while summing the selected window
package smc_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SUM, OUT} state_e;
  typedef enum logic [1:0] {CUTOFF, TRIODE, SAT} region_e;

  localparam int MODE_ID  = 0;
  localparam int MODE_MAX = 1;

  // Id batches weight the i-th selected result by K+i; gm batches are a plain sum.
  function automatic int unsigned weight(input int unsigned i, input int unsigned k,
                                         input logic is_id);
    return is_id ? (k + i) : 32'd1;
  endfunction

endpackage

// File: rtl/smc_stream_topk_dev_calc.sv
// smc_dev_calc: combinational single-device evaluator (Kn = 1/3, no body effect/CLM).
// Ports:
//   w, v_gs, v_ds - unsigned device geometry / bias (VW bits each)
//   is_id         - 1: drain current Id, 0: transconductance gm
//   res           - truncated result, RW bits
module smc_dev_calc
  import smc_pkg::*;
#(
  parameter int VW  = 3,
  parameter int VTH = 1,
  parameter int RW  = 3 * VW + 2
) (
  input  logic [VW-1:0] w,
  input  logic [VW-1:0] v_gs,
  input  logic [VW-1:0] v_ds,
  input  logic          is_id,
  output logic [RW-1:0] res
);

  localparam logic [RW-1:0] VTH_X = RW'(VTH);
  localparam logic [RW-1:0] THREE = RW'(3);

  logic [RW-1:0] w_x, gs_x, ds_x, ov_x, num;
  region_e       region;

  assign w_x  = RW'(w);
  assign gs_x = RW'(v_gs);
  assign ds_x = RW'(v_ds);
  assign ov_x = gs_x - VTH_X;

  always_comb begin
    if (gs_x <= VTH_X)              region = CUTOFF;
    else if (gs_x > ds_x + VTH_X)   region = TRIODE;
    else                            region = SAT;
  end

  // Whole numerator is built at RW bits before the single truncating divide.
  always_comb begin
    num = '0;
    case (region)
      TRIODE:  num = is_id ? ds_x * w_x * ((ov_x << 1) - ds_x) : (w_x * ds_x) << 1;
      SAT:     num = is_id ? w_x * ov_x * ov_x : (w_x * ov_x) << 1;
      default: num = '0;
    endcase
  end

  assign res = num / THREE;

endmodule

// File: rtl/smc_stream_topk.sv
// smc_stream_topk: streams N_DEV devices per batch, keeps a descending sorted list
// of their Id/gm results and emits the weighted sum of the K largest or smallest.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid, in_ready  - device handshake (accept = in_valid && in_ready)
//   mode                - [0] Id/gm, [1] largest/smallest; taken from first device
//   w, v_gs, v_ds       - device inputs
//   out_valid, out_n    - one-cycle result strobe and weighted sum (0 when idle)
//
// state | meaning
// IDLE  | waiting for first device of a batch
// LOAD  | accepting devices 2..N_DEV, inserting each into the sorted list
// SUM   | K cycles accumulating weighted window entries
// OUT   | result strobe; list and accumulator cleared on exit
module smc_stream_topk
  import smc_pkg::*;
#(
  parameter int N_DEV = 6,
  parameter int K     = 3,
  parameter int VW    = 3,
  parameter int VTH   = 1,
  localparam int RW   = 3 * VW + 2,
  localparam int OW   = RW + 2 * $clog2(2 * K)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    mode,
  input  logic [VW-1:0] w,
  input  logic [VW-1:0] v_gs,
  input  logic [VW-1:0] v_ds,
  output logic          out_valid,
  output logic [OW-1:0] out_n
);

  localparam int CW = $clog2(N_DEV + 1);
  localparam int IW = (N_DEV > 1) ? $clog2(N_DEV) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;

  state_e        state;
  logic [CW-1:0] count;
  logic [1:0]    mode_q;
  logic [KW-1:0] sum_cnt;
  logic [OW-1:0] acc;
  logic [RW-1:0] list_q   [N_DEV];
  logic [RW-1:0] list_ins [N_DEV];
  logic [N_DEV-1:0] keep;
  logic [RW-1:0] dev_res;
  logic          is_id_cur;
  logic          accept;
  logic [KW-1:0] sum_i;
  logic [IW-1:0] sel_idx;
  logic [OW-1:0] term;

  assign in_ready  = (state == IDLE) || (state == LOAD);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == OUT);
  assign out_n     = (state == OUT) ? acc : '0;

  // The first device of a batch is evaluated with the mode it brings in.
  assign is_id_cur = (state == IDLE) ? mode[MODE_ID] : mode_q[MODE_ID];

  smc_dev_calc #(.VW(VW), .VTH(VTH), .RW(RW)) u_calc (
    .w     (w),
    .v_gs  (v_gs),
    .v_ds  (v_ds),
    .is_id (is_id_cur),
    .res   (dev_res)
  );

  // keep[] marks the prefix of filled entries >= new value; since ties stay ahead,
  // the new value lands right after that prefix and the tail shifts down one slot.
  always_comb begin
    for (int j = 0; j < N_DEV; j++)
      keep[j] = (CW'(j) < count) && (list_q[j] >= dev_res);
    list_ins[0] = keep[0] ? list_q[0] : dev_res;
    for (int j = 1; j < N_DEV; j++) begin
      if (keep[j])          list_ins[j] = list_q[j];
      else if (keep[j-1])   list_ins[j] = dev_res;
      else                  list_ins[j] = list_q[j-1];
    end
  end

  // sum_cnt counts down K-1..0; sum_i is the matching ascending window slot.
  assign sum_i   = KW'(K - 1) - sum_cnt;
  assign sel_idx = mode_q[MODE_MAX] ? IW'(sum_i) : IW'(N_DEV - K) + IW'(sum_i);
  assign term    = OW'(weight(32'(sum_i), K, mode_q[MODE_ID])) * OW'(list_q[sel_idx]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      mode_q  <= '0;
      sum_cnt <= '0;
      acc     <= '0;
      for (int j = 0; j < N_DEV; j++) list_q[j] <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          mode_q <= mode;
          list_q <= list_ins;
          count  <= CW'(1);
          state  <= LOAD;
        end
        LOAD: if (accept) begin
          list_q <= list_ins;
          count  <= count + CW'(1);
          if (count == CW'(N_DEV - 1)) begin
            state   <= SUM;
            sum_cnt <= KW'(K - 1);
          end
        end
        SUM: begin
          acc <= acc + term;
          if (sum_cnt == '0) state <= OUT;
          else               sum_cnt <= sum_cnt - KW'(1);
        end
        OUT: begin
          state <= IDLE;
          count <= '0;
          acc   <= '0;
          for (int j = 0; j < N_DEV; j++) list_q[j] <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smc_stream_topk.sv
// tb_smc_stream_topk: randomized + directed bench for smc_stream_topk with a
// behavioural model (per-device formulas, full sort, window weighted sum).
module tb_smc_stream_topk;

  localparam int N_DEV = 6;
  localparam int K     = 3;
  localparam int VW    = 3;
  localparam int VTH   = 1;
  localparam int RW    = 3 * VW + 2;
  localparam int OW    = RW + 2 * $clog2(2 * K);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    mode;
  logic [VW-1:0] w, v_gs, v_ds;
  logic          out_valid;
  logic [OW-1:0] out_n;

  int total = 0;
  int bad   = 0;
  int n_pulses  = 0;
  int n_batches = 0;

  int dev_w  [N_DEV];
  int dev_gs [N_DEV];
  int dev_ds [N_DEV];

  smc_stream_topk #(.N_DEV(N_DEV), .K(K), .VW(VW), .VTH(VTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .w         (w),
    .v_gs      (v_gs),
    .v_ds      (v_ds),
    .out_valid (out_valid),
    .out_n     (out_n)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (out_valid === 1'b1) n_pulses++;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_res(input int dw, input int gs, input int ds, input bit is_id);
    int ov;
    ov = gs - VTH;
    if (gs <= VTH) return 0;
    if (gs > ds + VTH) return is_id ? (ds * dw * (2 * ov - ds)) / 3 : (2 * dw * ds) / 3;
    return is_id ? (dw * ov * ov) / 3 : (2 * dw * ov) / 3;
  endfunction

  function automatic longint ref_out(input logic [1:0] m);
    int v [N_DEV];
    int t;
    longint s;
    for (int i = 0; i < N_DEV; i++) v[i] = ref_res(dev_w[i], dev_gs[i], dev_ds[i], m[0]);
    for (int i = 0; i < N_DEV; i++)
      for (int j = 0; j < N_DEV - 1 - i; j++)
        if (v[j] < v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
    s = 0;
    for (int i = 0; i < K; i++)
      s += longint'(m[0] ? (K + i) : 1) * longint'(m[1] ? v[i] : v[N_DEV - K + i]);
    return s;
  endfunction

  task automatic junk();
    w    = VW'($urandom);
    v_gs = VW'($urandom);
    v_ds = VW'($urandom);
    mode = 2'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    junk();
    @(negedge clk);
    check_val("rst_in_ready", longint'(in_ready), 1);
    check_val("rst_out_valid", longint'(out_valid), 0);
    check_val("rst_out_n", longint'(out_n), 0);
    rst = 1'b0;
  endtask

  // Feeds nd devices from dev_* arrays; a full batch is then checked cycle by cycle.
  task automatic run_batch(input logic [1:0] m, input int nd, input int max_gap,
                           input bit hold, input bit use_gold, input longint gold);
    longint exp;
    int g;
    for (int d = 0; d < nd; d++) begin
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (g) begin
        @(negedge clk);
        in_valid = 1'b0;
        junk();
      end
      @(negedge clk);
      check_val("in_ready_load", longint'(in_ready), 1);
      in_valid = 1'b1;
      w    = VW'(dev_w[d]);
      v_gs = VW'(dev_gs[d]);
      v_ds = VW'(dev_ds[d]);
      mode = (d == 0) ? m : 2'($urandom);
    end
    if (nd < N_DEV) begin
      @(negedge clk);
      in_valid = 1'b0;
      return;
    end
    exp = use_gold ? gold : ref_out(m);
    for (int c = 1; c <= K + 1; c++) begin
      @(negedge clk);
      in_valid = hold;
      junk();
      if (c <= K) begin
        check_val("sum_out_valid", longint'(out_valid), 0);
        check_val("sum_out_n", longint'(out_n), 0);
        check_val("sum_in_ready", longint'(in_ready), 0);
      end else begin
        check_val("out_valid", longint'(out_valid), 1);
        check_val("out_n", longint'(out_n), exp);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    check_val("post_out_valid", longint'(out_valid), 0);
    check_val("post_out_n", longint'(out_n), 0);
    check_val("post_in_ready", longint'(in_ready), 1);
    n_batches++;
  endtask

  task automatic set_sweep(input bit desc);
    for (int i = 0; i < N_DEV; i++) begin
      dev_w[i]  = 3;
      dev_ds[i] = 7;
      dev_gs[i] = desc ? 7 - i : 2 + i;
    end
  endtask

  task automatic set_random();
    for (int i = 0; i < N_DEV; i++) begin
      dev_w[i]  = int'($urandom_range(7, 0));
      dev_gs[i] = int'($urandom_range(7, 0));
      dev_ds[i] = int'($urandom_range(7, 0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    junk();
    do_reset();

    for (int d = 0; d < 2; d++) begin
      set_sweep(d[0]);
      run_batch(2'b11, N_DEV, 0, 1'b0, 1'b1, 288);
      run_batch(2'b01, N_DEV, 2, 1'b1, 1'b1, 48);
      run_batch(2'b10, N_DEV, 0, 1'b1, 1'b1, 30);
      run_batch(2'b00, N_DEV, 2, 1'b0, 1'b1, 12);
    end

    for (int i = 0; i < N_DEV; i++) begin dev_w[i] = 3; dev_gs[i] = 3; dev_ds[i] = 3; end
    run_batch(2'b11, N_DEV, 1, 1'b1, 1'b1, 48);
    run_batch(2'b10, N_DEV, 0, 1'b0, 1'b1, 12);

    dev_w[0] = 7; dev_gs[0] = 7; dev_ds[0] = 1;
    for (int i = 1; i < N_DEV; i++) begin dev_w[i] = 5; dev_gs[i] = 0; dev_ds[i] = 4; end
    run_batch(2'b11, N_DEV, 0, 1'b1, 1'b1, 75);
    run_batch(2'b01, N_DEV, 0, 1'b0, 1'b1, 0);

    // Aborted batch: nothing may be emitted and the next batch must start clean.
    set_random();
    run_batch(2'b11, 3, 1, 1'b0, 1'b0, 0);
    do_reset();
    set_random();
    run_batch(2'($urandom), N_DEV, 2, 1'b1, 1'b0, 0);

    for (int b = 0; b < 24; b++) begin
      set_random();
      run_batch(2'($urandom), N_DEV, int'($urandom_range(3, 0)), 1'($urandom), 1'b0, 0);
    end

    repeat (3) @(negedge clk);
    check_val("pulse_count", longint'(n_pulses), longint'(n_batches));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
